// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline scheduling control.
package pipe_ctrl_pkg;
    localparam int NREG  = 8;
    localparam int REG_W = 3;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [1:0]       pend_cnt_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrl_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of in-flight writers, with two operand read ports,
// a destination saturation flag and an all-idle flag.
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG = pipe_ctrl_pkg::NREG
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      inc_en_i,
    input  reg_idx_t  inc_idx_i,
    input  logic      dec_en_i,
    input  reg_idx_t  dec_idx_i,
    input  reg_idx_t  rd_a_idx_i,
    input  reg_idx_t  rd_b_idx_i,
    input  reg_idx_t  sat_idx_i,
    output pend_cnt_t rd_a_cnt_o,
    output pend_cnt_t rd_b_cnt_o,
    output logic      sat_o,
    output logic      all_zero_o
);

    pend_cnt_t cnt_q [NREG];
    pend_cnt_t cnt_d [NREG];

    // An issue and a retire hitting the same register cancel out.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_en_i && (inc_idx_i == reg_idx_t'(i)) &&
                !(dec_en_i && (dec_idx_i == reg_idx_t'(i))) && (cnt_q[i] != 2'd3))
                cnt_d[i] = cnt_q[i] + 2'd1;
            else if (dec_en_i && (dec_idx_i == reg_idx_t'(i)) &&
                     !(inc_en_i && (inc_idx_i == reg_idx_t'(i))) && (cnt_q[i] != 2'd0))
                cnt_d[i] = cnt_q[i] - 2'd1;
        end
    end

    // NOTE: this count array is control state, not a data RAM, so every entry
    // is reset; stale counts after reset would deadlock the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        all_zero_o = 1'b1;
        for (int i = 0; i < NREG; i++)
            if (cnt_q[i] != 2'd0) all_zero_o = 1'b0;
    end

    assign rd_a_cnt_o = cnt_q[rd_a_idx_i];
    assign rd_b_cnt_o = cnt_q[rd_b_idx_i];
    assign sat_o      = (cnt_q[sat_idx_i] == 2'd3);

    // A retirement with no writer in flight points at a broken pipeline.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (dec_en_i && !(inc_en_i && (inc_idx_i == dec_idx_i))) |-> (cnt_q[dec_idx_i] != 2'd0));

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush decision for the ID stage: RAW scoreboard, multi-cycle
// EX occupancy, taken-branch squash and halt drain.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG         = pipe_ctrl_pkg::NREG,
    parameter int MULTI_LAT    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic [2:0] id_rd,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_writes_rd,
    input  logic       id_is_multi,
    input  logic       ex_branch_taken,
    input  logic       wb_valid,
    input  logic [2:0] wb_rd,
    input  logic       halt_req,
    output logic       id_issue,
    output logic       if_stall,
    output logic       id_bubble,
    output logic       if_flush,
    output logic [1:0] ctrl_state,
    output logic       halted
);

    localparam int BUSY_W = (MULTI_LAT > 2) ? $clog2(MULTI_LAT) : 1;
    localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BUSY_W-1:0] BUSY_LOAD  = BUSY_W'(MULTI_LAT - 1);
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    ctrl_state_t       state_q, state_d;
    logic [BUSY_W-1:0] busy_q,  busy_d;
    logic [FCNT_W-1:0] fcnt_q,  fcnt_d;

    pend_cnt_t cnt_rs, cnt_rt;
    logic      rd_sat, sb_idle, hazard;
    logic      issue_c, stall_c, bubble_c, flush_c, halted_c;

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en_i  (issue_c & id_writes_rd),
        .inc_idx_i (id_rd),
        .dec_en_i  (wb_valid),
        .dec_idx_i (wb_rd),
        .rd_a_idx_i(id_rs),
        .rd_b_idx_i(id_rt),
        .sat_idx_i (id_rd),
        .rd_a_cnt_o(cnt_rs),
        .rd_b_cnt_o(cnt_rt),
        .sat_o     (rd_sat),
        .all_zero_o(sb_idle)
    );

    // Registered counts only: a same-cycle writeback does not release a stall.
    assign hazard = id_valid & ((id_uses_rs & (cnt_rs != 2'd0)) |
                                (id_uses_rt & (cnt_rt != 2'd0)) |
                                (id_writes_rd & rd_sat) |
                                (busy_q != '0));

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        issue_c  = 1'b0;
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        halted_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    // The redirect cycle is the first of the squash window.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end else begin
                    issue_c  = id_valid & ~hazard & ~halt_req;
                    stall_c  = id_valid & hazard;
                    bubble_c = id_valid & hazard;
                    if (halt_req) state_d = DRAIN;
                end
            end
            FLUSH: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (fcnt_q == '0) state_d = RUN;
                else              fcnt_d  = fcnt_q - FCNT_W'(1);
            end
            DRAIN: begin
                stall_c  = 1'b1;
                bubble_c = id_valid;
                if (!halt_req)                        state_d = RUN;
                else if (sb_idle && (busy_q == '0))   state_d = HALTED;
            end
            HALTED: begin
                halted_c = 1'b1;
                stall_c  = 1'b1;
                bubble_c = id_valid;
                if (!halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (issue_c && id_is_multi) busy_d = BUSY_LOAD;
        else if (busy_q != '0)      busy_d = busy_q - BUSY_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Outputs are forced low during reset even though ID may present valid data.
    assign id_issue   = rst_n & issue_c;
    assign if_stall   = rst_n & stall_c;
    assign id_bubble  = rst_n & bubble_c;
    assign if_flush   = rst_n & flush_c;
    assign halted     = rst_n & halted_c;
    assign ctrl_state = state_q;

    a_no_branch_in_flush: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == FLUSH) |-> !ex_branch_taken);

endmodule
